// File: rtl/lcd_text_pkg.sv
// Shared definitions for the character-LCD text path: frame geometry, fill and
// replacement characters, command codes and the buffer FSM state encoding.
package lcd_text_pkg;

    localparam int NUM_CHARS = 32;
    localparam int CUR_W     = 5;
    localparam int FRAME_W   = NUM_CHARS * 8;

    localparam logic [7:0] BLANK_CHAR_DEFAULT = 8'h20;
    localparam logic [7:0] REPL_CHAR_DEFAULT  = 8'h3F;

    localparam logic [7:0] CMD_CLEAR       = 8'h01;
    localparam logic [7:0] CMD_HOME        = 8'h02;
    localparam logic [7:0] CMD_COMMIT      = 8'h03;
    // SETPOS is 8'b100x_xxxx: match the top three bits, low five carry the position.
    localparam logic [7:0] CMD_SETPOS_MASK = 8'hE0;
    localparam logic [7:0] CMD_SETPOS_VAL  = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/lcd_char_filter.sv
// Maps a byte to itself when it is printable ASCII (8'h20..8'h7E), otherwise to
// the replacement character. Purely combinational; shared by all text sources.
module lcd_char_filter
    import lcd_text_pkg::*;
#(
    parameter logic [7:0] REPL_CHAR = REPL_CHAR_DEFAULT
) (
    input  logic [7:0] char_in,
    output logic [7:0] char_out
);

    assign char_out = ((char_in < 8'h20) || (char_in > 8'h7E)) ? REPL_CHAR : char_in;

endmodule

// File: rtl/lcd_text_buffer.sv
// Edits a 32-char shadow frame from a byte stream of characters and commands and
// publishes it on `data` only at commit, so the LCD driver never sees a partial edit.
module lcd_text_buffer
    import lcd_text_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR  = BLANK_CHAR_DEFAULT,
    parameter logic [7:0] REPL_CHAR   = REPL_CHAR_DEFAULT,
    parameter bit         AUTO_COMMIT = 1'b0
) (
    input  logic               LCDCLK,
    input  logic               PRESET,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               wr_is_cmd,
    input  logic [7:0]         wr_data,
    output logic [FRAME_W-1:0] data,
    output logic               data_update,
    output logic [CUR_W-1:0]   cursor,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [CUR_W-1:0]   cursor_q, cursor_d;
    logic [CUR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [7:0]         shadow_q [NUM_CHARS];
    logic [7:0]         shadow_d [NUM_CHARS];
    logic [FRAME_W-1:0] data_q, data_d;
    logic               data_update_q, data_update_d;
    logic [7:0]         char_filt;
    logic               accept;

    lcd_char_filter #(.REPL_CHAR(REPL_CHAR)) u_filter (
        .char_in  (wr_data),
        .char_out (char_filt)
    );

    // Handshake: a byte transfers on an LCDCLK rise where wr_valid & wr_ready.
    // wr_ready depends only on registered state (and reset), never on wr_valid,
    // so an offered byte simply waits while the buffer is busy.
    assign wr_ready    = (state_q == ST_IDLE) & ~PRESET;
    assign accept      = wr_valid & wr_ready;
    assign busy        = (state_q != ST_IDLE);
    assign data        = data_q;
    assign data_update = data_update_q;
    assign cursor      = cursor_q;

    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        clr_idx_d     = clr_idx_q;
        shadow_d      = shadow_q;
        data_d        = data_q;
        data_update_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!wr_is_cmd) begin
                        shadow_d[cursor_q] = char_filt;
                        cursor_d           = cursor_q + 1'b1;
                        if (AUTO_COMMIT && (cursor_q == CUR_W'(NUM_CHARS - 1))) begin
                            state_d = ST_COMMIT;
                        end
                    end else if (wr_data == CMD_CLEAR) begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = '0;
                    end else if (wr_data == CMD_HOME) begin
                        cursor_d = '0;
                    end else if (wr_data == CMD_COMMIT) begin
                        state_d = ST_COMMIT;
                    end else if ((wr_data & CMD_SETPOS_MASK) == CMD_SETPOS_VAL) begin
                        cursor_d = wr_data[CUR_W-1:0];
                    end
                end
            end
            ST_CLEAR: begin
                shadow_d[clr_idx_q] = BLANK_CHAR;
                clr_idx_d           = clr_idx_q + 1'b1;
                if (clr_idx_q == CUR_W'(NUM_CHARS - 1)) begin
                    cursor_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                // Char 0 lands in the top byte of the published frame.
                for (int i = 0; i < NUM_CHARS; i++) begin
                    data_d[FRAME_W-1-8*i -: 8] = shadow_q[i];
                end
                data_update_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge LCDCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            cursor_q      <= '0;
            clr_idx_q     <= '0;
            data_q        <= {NUM_CHARS{BLANK_CHAR}};
            data_update_q <= 1'b0;
            for (int i = 0; i < NUM_CHARS; i++) begin
                shadow_q[i] <= BLANK_CHAR;
            end
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            clr_idx_q     <= clr_idx_d;
            data_q        <= data_d;
            data_update_q <= data_update_d;
            shadow_q      <= shadow_d;
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Bench for lcd_text_buffer: one manual-commit and one auto-commit instance, a
// frame-level reference model and a scoreboard of expected published frames.
module tb_lcd_text_buffer;

    localparam logic [255:0] ALL_BLANK = {32{8'h20}};

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         wr_valid    [2];
    logic         wr_is_cmd   [2];
    logic [7:0]   wr_data     [2];
    logic         wr_ready    [2];
    logic [255:0] data        [2];
    logic         data_update [2];
    logic [4:0]   cursor      [2];
    logic         busy        [2];

    lcd_text_buffer #(.AUTO_COMMIT(1'b0)) dut0 (
        .LCDCLK(clk), .PRESET(rst),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_is_cmd(wr_is_cmd[0]),
        .wr_data(wr_data[0]), .data(data[0]), .data_update(data_update[0]),
        .cursor(cursor[0]), .busy(busy[0])
    );

    lcd_text_buffer #(.AUTO_COMMIT(1'b1)) dut1 (
        .LCDCLK(clk), .PRESET(rst),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_is_cmd(wr_is_cmd[1]),
        .wr_data(wr_data[1]), .data(data[1]), .data_update(data_update[1]),
        .cursor(cursor[1]), .busy(busy[1])
    );

    int vectors    = 0;
    int miscompares = 0;

    // reference model: character array per instance, cursor, published frame
    logic [7:0]   m_sh   [2][32];
    int           m_cur  [2];
    logic [255:0] m_data [2];
    logic [255:0] exp_q0 [$];
    logic [255:0] exp_q1 [$];

    int           upd_cnt [2];
    int           acc_cnt [2];
    logic [255:0] prev_data [2];
    logic [255:0] mon_exp;
    bit           mon_have;

    function automatic logic [7:0] filt(input logic [7:0] b);
        return ((b < 8'h20) || (b > 8'h7E)) ? 8'h3F : b;
    endfunction

    function automatic logic [255:0] frame_of(input int s);
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[255-8*i -: 8] = m_sh[s][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 32; i++) m_sh[s][i] = 8'h20;
            m_cur[s]  = 0;
            m_data[s] = ALL_BLANK;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_commit(input int s);
        m_data[s] = frame_of(s);
        if (s == 0) exp_q0.push_back(m_data[s]);
        else        exp_q1.push_back(m_data[s]);
    endtask

    task automatic model_apply(input int s, input logic c, input logic [7:0] b);
        int was;
        if (!c) begin
            was          = m_cur[s];
            m_sh[s][was] = filt(b);
            m_cur[s]     = (was + 1) % 32;
            if (s == 1 && was == 31) model_commit(s);
        end else if (b == 8'h01) begin
            for (int i = 0; i < 32; i++) m_sh[s][i] = 8'h20;
            m_cur[s] = 0;
        end else if (b == 8'h02) begin
            m_cur[s] = 0;
        end else if (b == 8'h03) begin
            model_commit(s);
        end else if (b[7:5] == 3'b100) begin
            m_cur[s] = int'(b[4:0]);
        end
    endtask

    // scoreboard: every data_update must publish the next expected frame, and
    // data may not move at any other time except under reset
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                prev_data[s] = ALL_BLANK;
            end else if (data_update[s]) begin
                upd_cnt[s]++;
                vectors++;
                mon_have = 1'b0;
                if (s == 0 && exp_q0.size() > 0) begin mon_exp = exp_q0.pop_front(); mon_have = 1'b1; end
                if (s == 1 && exp_q1.size() > 0) begin mon_exp = exp_q1.pop_front(); mon_have = 1'b1; end
                if (!mon_have) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_update dut%0d data=%h required no update", s, data[s]);
                end else if (data[s] !== mon_exp) begin
                    miscompares++;
                    $display("FAIL sb_frame dut%0d data=%h required %h", s, data[s], mon_exp);
                end
                prev_data[s] = data[s];
            end else begin
                vectors++;
                if (data[s] !== prev_data[s]) begin
                    miscompares++;
                    $display("FAIL sb_data_stable dut%0d data=%h required %h", s, data[s], prev_data[s]);
                    prev_data[s] = data[s];
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) if (wr_valid[s] && wr_ready[s]) acc_cnt[s]++;
    end

    // driver: offer one byte, hold it until accepted, update the model on accept
    task automatic send(input int s, input logic c, input logic [7:0] b);
        int n = 0;
        wr_valid[s]  = 1'b1;
        wr_is_cmd[s] = c;
        wr_data[s]   = b;
        while (wr_ready[s] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (wr_ready[s] !== 1'b1) begin
            miscompares++;
            $display("FAIL send_timeout dut%0d wr_ready=%b required 1", s, wr_ready[s]);
        end else begin
            @(posedge clk); #1;
            model_apply(s, c, b);
        end
        wr_valid[s] = 1'b0;
    endtask

    task automatic wait_ready(input int s);
        int n = 0;
        while (wr_ready[s] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (wr_ready[s] !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout dut%0d wr_ready=%b required 1", s, wr_ready[s]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            wr_valid[s] = 1'b0; wr_is_cmd[s] = 1'b0; wr_data[s] = 8'h00;
            upd_cnt[s] = 0; acc_cnt[s] = 0; prev_data[s] = ALL_BLANK;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            vectors += 4;
            if (wr_ready[s] !== 1'b0) begin miscompares++; $display("FAIL rst_ready dut%0d got %b required 0", s, wr_ready[s]); end
            if (busy[s] !== 1'b0) begin miscompares++; $display("FAIL rst_busy dut%0d got %b required 0", s, busy[s]); end
            if (data_update[s] !== 1'b0) begin miscompares++; $display("FAIL rst_update dut%0d got %b required 0", s, data_update[s]); end
            if (data[s] !== ALL_BLANK) begin miscompares++; $display("FAIL rst_data dut%0d got %h required %h", s, data[s], ALL_BLANK); end
        end
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            vectors += 3;
            if (wr_ready[s] !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready dut%0d got %b required 1", s, wr_ready[s]); end
            if (cursor[s] !== 5'd0) begin miscompares++; $display("FAIL post_rst_cursor dut%0d got %0d required 0", s, cursor[s]); end
            if (data[s] !== ALL_BLANK) begin miscompares++; $display("FAIL post_rst_data dut%0d got %h required %h", s, data[s], ALL_BLANK); end
        end
        repeat (6) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (upd_cnt[s] !== 0) begin miscompares++; $display("FAIL idle_no_update dut%0d pulses %0d required 0", s, upd_cnt[s]); end
        end
    endtask

    task automatic test_hello();
        string        msg = "HELLO";
        logic [39:0]  hello = "HELLO";
        logic [215:0] rest_blank = {27{8'h20}};
        int           upd0;
        for (int i = 0; i < msg.len(); i++) send(0, 1'b0, msg[i]);
        upd0 = upd_cnt[0];
        send(0, 1'b1, 8'h03);
        vectors += 3;
        if (wr_ready[0] !== 1'b0) begin miscompares++; $display("FAIL commit_ready_low got %b required 0", wr_ready[0]); end
        if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL commit_busy got %b required 1", busy[0]); end
        if (data_update[0] !== 1'b0) begin miscompares++; $display("FAIL commit_early_update got %b required 0", data_update[0]); end
        @(posedge clk); #1;
        vectors += 5;
        if (data_update[0] !== 1'b1) begin miscompares++; $display("FAIL commit_update got %b required 1", data_update[0]); end
        if (data[0][255:216] !== hello) begin miscompares++; $display("FAIL hello_text got %h required %h", data[0][255:216], hello); end
        if (data[0][215:0] !== rest_blank) begin miscompares++; $display("FAIL hello_rest got %h required %h", data[0][215:0], rest_blank); end
        if (wr_ready[0] !== 1'b1) begin miscompares++; $display("FAIL commit_ready_back got %b required 1", wr_ready[0]); end
        if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL commit_busy_clear got %b required 0", busy[0]); end
        @(posedge clk); #1;
        vectors += 3;
        if (data_update[0] !== 1'b0) begin miscompares++; $display("FAIL update_one_cycle got %b required 0", data_update[0]); end
        if (cursor[0] !== 5'd5) begin miscompares++; $display("FAIL hello_cursor got %0d required 5", cursor[0]); end
        if (upd_cnt[0] !== upd0 + 1) begin miscompares++; $display("FAIL hello_pulses got %0d required %0d", upd_cnt[0], upd0 + 1); end
    endtask

    task automatic test_setpos();
        send(0, 1'b1, 8'h90);
        send(0, 1'b0, 8'h41);
        send(0, 1'b1, 8'h03);
        @(posedge clk); #1;
        vectors += 2;
        if (data[0][127:120] !== 8'h41) begin miscompares++; $display("FAIL setpos_char got %h required 41", data[0][127:120]); end
        if (cursor[0] !== 5'd17) begin miscompares++; $display("FAIL setpos_cursor got %0d required 17", cursor[0]); end
        send(0, 1'b0, 8'h07);
        send(0, 1'b1, 8'h03);
        @(posedge clk); #1;
        vectors += 3;
        if (data[0][119:112] !== 8'h3F) begin miscompares++; $display("FAIL nonprint_repl got %h required 3f", data[0][119:112]); end
        if (data[0] !== m_data[0]) begin miscompares++; $display("FAIL setpos_frame got %h required %h", data[0], m_data[0]); end
        if (cursor[0] !== 5'd18) begin miscompares++; $display("FAIL nonprint_cursor got %0d required 18", cursor[0]); end
    endtask

    task automatic test_clear_held();
        logic [255:0] old;
        int acc0, upd0, lowc;
        bit changed = 1'b0;
        send(0, 1'b1, 8'h80);
        for (int i = 0; i < 32; i++) send(0, 1'b0, 8'($urandom_range(8'h21, 8'h7E)));
        send(0, 1'b1, 8'h03);
        @(posedge clk); #1;
        vectors += 2;
        if (data[0] !== m_data[0]) begin miscompares++; $display("FAIL fill_frame got %h required %h", data[0], m_data[0]); end
        if (cursor[0] !== 5'd0) begin miscompares++; $display("FAIL fill_wrap_cursor got %0d required 0", cursor[0]); end
        for (int i = 0; i < 3; i++) send(0, 1'b0, 8'($urandom_range(8'h21, 8'h7E)));
        send(0, 1'b1, 8'h01);
        old  = data[0];
        acc0 = acc_cnt[0];
        upd0 = upd_cnt[0];
        wr_valid[0] = 1'b1; wr_is_cmd[0] = 1'b1; wr_data[0] = 8'h03;
        lowc = 0;
        while (wr_ready[0] !== 1'b1 && lowc < 100) begin
            if (data[0] !== old) changed = 1'b1;
            lowc++;
            @(posedge clk); #1;
        end
        vectors += 2;
        if (lowc !== 32) begin miscompares++; $display("FAIL clear_ready_low cycles %0d required 32", lowc); end
        if (changed || upd_cnt[0] !== upd0) begin miscompares++; $display("FAIL clear_data_held changed=%0d pulses=%0d required 0/%0d", changed, upd_cnt[0], upd0); end
        @(posedge clk); #1;
        model_apply(0, 1'b1, 8'h03);
        wr_valid[0] = 1'b0;
        @(posedge clk); #1;
        vectors += 3;
        if (data_update[0] !== 1'b1) begin miscompares++; $display("FAIL held_commit_update got %b required 1", data_update[0]); end
        if (data[0] !== ALL_BLANK) begin miscompares++; $display("FAIL clear_commit_blank got %h required %h", data[0], ALL_BLANK); end
        if (cursor[0] !== 5'd0) begin miscompares++; $display("FAIL clear_cursor got %0d required 0", cursor[0]); end
        repeat (4) @(posedge clk);
        #1;
        vectors += 2;
        if (acc_cnt[0] !== acc0 + 1) begin miscompares++; $display("FAIL held_accept_once got %0d required %0d", acc_cnt[0] - acc0, 1); end
        if (upd_cnt[0] !== upd0 + 1) begin miscompares++; $display("FAIL held_commit_once got %0d required %0d", upd_cnt[0] - upd0, 1); end
    endtask

    task automatic test_back_to_back_auto();
        time t0;
        int  cycles;
        t0 = $time;
        for (int i = 0; i < 32; i++) send(1, 1'b0, 8'($urandom_range(0, 255)));
        cycles = int'(($time - t0) / 10);
        vectors += 4;
        if (cycles !== 32) begin miscompares++; $display("FAIL auto_back_to_back cycles %0d required 32", cycles); end
        if (upd_cnt[1] !== 0) begin miscompares++; $display("FAIL auto_early_commit pulses %0d required 0", upd_cnt[1]); end
        if (data_update[1] !== 1'b0) begin miscompares++; $display("FAIL auto_update_early got %b required 0", data_update[1]); end
        if (busy[1] !== 1'b1) begin miscompares++; $display("FAIL auto_busy got %b required 1", busy[1]); end
        @(posedge clk); #1;
        vectors += 3;
        if (data_update[1] !== 1'b1) begin miscompares++; $display("FAIL auto_update got %b required 1", data_update[1]); end
        if (data[1] !== m_data[1]) begin miscompares++; $display("FAIL auto_frame got %h required %h", data[1], m_data[1]); end
        if (cursor[1] !== 5'd0) begin miscompares++; $display("FAIL auto_cursor got %0d required 0", cursor[1]); end
    endtask

    task automatic test_reset_mid_clear();
        int cur_before;
        send(0, 1'b0, 8'h58);
        send(0, 1'b0, 8'h59);
        send(0, 1'b1, 8'h03);
        @(posedge clk); #1;
        send(0, 1'b1, 8'h01);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            vectors += 5;
            if (wr_ready[s] !== 1'b0) begin miscompares++; $display("FAIL abort_ready dut%0d got %b required 0", s, wr_ready[s]); end
            if (busy[s] !== 1'b0) begin miscompares++; $display("FAIL abort_busy dut%0d got %b required 0", s, busy[s]); end
            if (data_update[s] !== 1'b0) begin miscompares++; $display("FAIL abort_update dut%0d got %b required 0", s, data_update[s]); end
            if (cursor[s] !== 5'd0) begin miscompares++; $display("FAIL abort_cursor dut%0d got %0d required 0", s, cursor[s]); end
            if (data[s] !== ALL_BLANK) begin miscompares++; $display("FAIL abort_data dut%0d got %h required %h", s, data[s], ALL_BLANK); end
        end
        model_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        vectors += 3;
        if (wr_ready[0] !== 1'b1) begin miscompares++; $display("FAIL abort_idle got %b required 1", wr_ready[0]); end
        if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL abort_idle_busy got %b required 0", busy[0]); end
        if (data[0] !== ALL_BLANK) begin miscompares++; $display("FAIL abort_idle_data got %h required %h", data[0], ALL_BLANK); end
        send(0, 1'b0, 8'h51);
        cur_before = m_cur[0];
        send(0, 1'b1, 8'h55);
        @(posedge clk); #1;
        vectors += 3;
        if (cursor[0] !== 5'(cur_before)) begin miscompares++; $display("FAIL unknown_cmd_cursor got %0d required %0d", cursor[0], cur_before); end
        if (busy[0] !== 1'b0 || wr_ready[0] !== 1'b1) begin miscompares++; $display("FAIL unknown_cmd_state busy=%b ready=%b required 0/1", busy[0], wr_ready[0]); end
        if (data[0] !== ALL_BLANK) begin miscompares++; $display("FAIL unknown_cmd_data got %h required %h", data[0], ALL_BLANK); end
        send(0, 1'b1, 8'h03);
        @(posedge clk); #1;
        vectors++;
        if (data[0] !== m_data[0]) begin miscompares++; $display("FAIL post_abort_frame got %h required %h", data[0], m_data[0]); end
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      send(0, 1'b0, 8'($urandom_range(0, 255)));
            else if (r == 6) send(0, 1'b1, 8'h80 | 8'($urandom_range(0, 31)));
            else if (r == 7) send(0, 1'b1, 8'h02);
            else if (r == 8) send(0, 1'b1, 8'h03);
            else             send(0, 1'b1, 8'($urandom_range(0, 255)));
            wait_ready(0);
            vectors++;
            if (cursor[0] !== 5'(m_cur[0])) begin
                miscompares++;
                $display("FAIL rand_cursor op %0d got %0d required %0d", k, cursor[0], m_cur[0]);
            end
        end
        send(0, 1'b1, 8'h03);
        @(posedge clk); #1;
        vectors++;
        if (data[0] !== m_data[0]) begin miscompares++; $display("FAIL rand_final_frame got %h required %h", data[0], m_data[0]); end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_setpos();
        test_clear_held();
        test_back_to_back_auto();
        test_reset_mid_clear();
        test_random();
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL sb_pending_frames dut0=%0d dut1=%0d required 0", exp_q0.size(), exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
